// File: rtl/hamming_secded_decoder.sv
// Pipelined Hamming SEC-DED decoder with a valid/ready stream interface and
// saturating corrected/uncorrectable error counters.
module hamming_secded_decoder #(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W+PAR_W:0]   cw_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       dout,
  output logic                    err_corr,
  output logic                    err_uncorr,
  output logic [PAR_W-1:0]        err_pos,
  output logic [CNT_W-1:0]        corr_cnt,
  output logic [CNT_W-1:0]        uncorr_cnt,
  input  logic                    cnt_clr
);

  localparam int N    = DATA_W + PAR_W;
  localparam int CW_W = N + 1;

  localparam logic [PAR_W-1:0] N_POS   = PAR_W'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The syndrome must be able to name every position, and the highest parity
  // position must land inside the codeword, or the data layout breaks.
  if ((1 << PAR_W) < N + 1) begin : g_bad_par_w
    $error("hamming_secded_decoder: PAR_W too small for DATA_W");
  end
  if ((1 << (PAR_W - 1)) > N) begin : g_bad_layout
    $error("hamming_secded_decoder: PAR_W too large for DATA_W");
  end

  // Codeword position of data bit k: the k-th non-power-of-two position.
  function automatic int data_pos(input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) res = p;
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

  logic                   s1_valid_q, s1_valid_d;
  logic [CW_W-1:0]        s1_cw_q, s1_cw_d;
  logic [PAR_W-1:0]       s1_syn_q, s1_syn_d;
  logic                   s1_par_q, s1_par_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   err_corr_q, err_corr_d;
  logic                   err_uncorr_q, err_uncorr_d;
  logic [PAR_W-1:0]       err_pos_q, err_pos_d;

  logic [CNT_W-1:0]       corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]       uncorr_cnt_q, uncorr_cnt_d;

  logic                   load_s1, load_s2, out_hs;
  logic [PAR_W-1:0]       syn_in;
  logic                   par_in;

  logic                   syn_zero, syn_in_range;
  logic                   is_single, is_par_only, is_uncorr;
  logic [CW_W-1:0]        flip_mask, cw_fix;
  logic [DATA_W-1:0]      raw_data, fix_data;
  logic                   unused_bits;

  assign load_s2  = !s2_valid_q || out_ready;
  assign load_s1  = !s1_valid_q || load_s2;
  assign in_ready = load_s1;
  assign out_hs   = s2_valid_q && out_ready;

  assign par_in = ^cw_in;

  // Syndrome of the incoming codeword: XOR of the indices of all set bits.
  always_comb begin
    syn_in = '0;
    for (int i = 1; i <= N; i++) begin
      if (cw_in[i]) syn_in = syn_in ^ PAR_W'(i);
    end
  end

  // Stage 1 captures the codeword with its syndrome and overall parity.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (load_s1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cw_d  = cw_in;
        s1_syn_d = syn_in;
        s1_par_d = par_in;
      end
    end
  end

  // Classify the stage-1 word and build the single-bit correction mask.
  always_comb begin
    syn_zero     = (s1_syn_q == '0);
    syn_in_range = (s1_syn_q <= N_POS);
    is_single    = s1_par_q && !syn_zero && syn_in_range;
    is_par_only  = s1_par_q && syn_zero;
    is_uncorr    = (!syn_zero && !s1_par_q) || (s1_par_q && !syn_in_range);
    flip_mask    = is_single ? (CW_W'(1) << s1_syn_q) : '0;
    cw_fix       = s1_cw_q ^ flip_mask;
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    localparam int POS = data_pos(k);
    assign raw_data[k] = s1_cw_q[POS];
    assign fix_data[k] = cw_fix[POS];
  end

  // Parity positions are only needed for the syndrome, not for extraction.
  assign unused_bits = ^{s1_cw_q, cw_fix};

  // Stage 2 registers the decoded data and flags; it holds while stalled.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    dout_d       = dout_q;
    err_corr_d   = err_corr_q;
    err_uncorr_d = err_uncorr_q;
    err_pos_d    = err_pos_q;
    if (load_s2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        dout_d       = is_uncorr ? raw_data : fix_data;
        err_corr_d   = is_single || is_par_only;
        err_uncorr_d = is_uncorr;
        err_pos_d    = is_single ? s1_syn_q : '0;
      end
    end
  end

  // Saturating error counters, advanced once per output handshake.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_hs) begin
      if (err_corr_q && corr_cnt_q != CNT_MAX)
        corr_cnt_d = corr_cnt_q + 1'b1;
      if (err_uncorr_q && uncorr_cnt_q != CNT_MAX)
        uncorr_cnt_d = uncorr_cnt_q + 1'b1;
    end
  end

  // State registers; reset discards in-flight words and clears the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_cw_q      <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      dout_q       <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      err_pos_q    <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_cw_q      <= s1_cw_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s2_valid_q   <= s2_valid_d;
      dout_q       <= dout_d;
      err_corr_q   <= err_corr_d;
      err_uncorr_q <= err_uncorr_d;
      err_pos_q    <= err_pos_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign dout       = dout_q;
  assign err_corr   = err_corr_q;
  assign err_uncorr = err_uncorr_q;
  assign err_pos    = err_pos_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule
